// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the CPU sequencer: FSM states, beat one-hots and the strobe bundle.
package cpu_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [3:0] T0 = 4'b0001;
    localparam logic [3:0] T1 = 4'b0010;
    localparam logic [3:0] T2 = 4'b0100;
    localparam logic [3:0] T3 = 4'b1000;

    typedef struct packed {
        logic mem_rd;
        logic ir_load;
        logic pc_inc;
        logic exec_en;
        logic wb_en;
    } strobe_t;

endpackage

// File: rtl/beat_gen.sv
// Four-beat one-hot ring counter; clear parks it at 0000, the next enabled edge restarts at T0.
module beat_gen
    import cpu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       hold,
    output logic [3:0] t
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t <= 4'b0000;
        end else if (clr) begin
            t <= 4'b0000;
        end else if (en && !hold) begin
            t <= (t == 4'b0000) ? T0 : {t[2:0], t[3]};
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: four-beat FSM with memory stall timeout, stop latch and retire counter.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step_mode,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic [3:0]       t,
    output logic [1:0]       state,
    output logic             mem_rd,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             exec_en,
    output logic             wb_en,
    output logic             fault,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int unsigned STALL_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    logic [1:0]         state_q, state_d;
    strobe_t            stb_q, stb_d;
    logic               fault_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stop_q, stop_d;
    logic               beat_clr, beat_en, beat_hold;

    beat_gen u_beat_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (beat_clr),
        .en   (beat_en),
        .hold (beat_hold),
        .t    (t)
    );

    // Next state, next beat control and the strobes that accompany the next beat.
    always_comb begin
        state_d   = state_q;
        stb_d     = '0;
        fault_d   = fault;
        cnt_d     = instr_cnt;
        stall_d   = stall_q;
        stop_d    = 1'b0;
        beat_clr  = 1'b0;
        beat_en   = 1'b0;
        beat_hold = 1'b0;

        case (state_q)
            ST_IDLE: begin
                beat_clr = 1'b1;
                stall_d  = '0;
                if (start && !stop) begin
                    state_d      = ST_FETCH;
                    beat_clr     = 1'b0;
                    beat_en      = 1'b1;
                    stb_d.mem_rd = 1'b1;
                end
            end
            ST_FETCH: begin
                beat_en = 1'b1;
                stop_d  = stop_q | stop;
                if (t == T1 && stb_q.ir_load) begin
                    stb_d.pc_inc = 1'b1;
                    stall_d      = '0;
                end else if (t == T0 || t == T1) begin
                    // T1 is repeated until a cycle carries ir_load; mem_ready here decides that cycle.
                    beat_hold = (t == T1);
                    if (mem_ready) begin
                        stb_d.mem_rd  = 1'b1;
                        stb_d.ir_load = 1'b1;
                        stall_d       = '0;
                    end else if (stall_q == STALL_MAX) begin
                        state_d  = ST_HALT;
                        fault_d  = 1'b1;
                        beat_clr = 1'b1;
                    end else begin
                        stb_d.mem_rd = 1'b1;
                        stall_d      = stall_q + 1'b1;
                    end
                end else if (t == T3) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                beat_en = 1'b1;
                stop_d  = stop_q | stop;
                case (t)
                    T0: stb_d.exec_en = 1'b1;
                    T2: stb_d.wb_en   = 1'b1;
                    T3: begin
                        cnt_d  = instr_cnt + CNT_W'(1);
                        stop_d = 1'b0;
                        if (halt_req) begin
                            state_d  = ST_HALT;
                            beat_clr = 1'b1;
                        end else if (stop_q || stop || step_mode) begin
                            state_d  = ST_IDLE;
                            beat_clr = 1'b1;
                        end else begin
                            state_d      = ST_FETCH;
                            stb_d.mem_rd = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                beat_clr = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                beat_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            stb_q     <= '0;
            fault     <= 1'b0;
            instr_cnt <= '0;
            stall_q   <= '0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stb_q     <= stb_d;
            fault     <= fault_d;
            instr_cnt <= cnt_d;
            stall_q   <= stall_d;
            stop_q    <= stop_d;
        end
    end

    assign state   = state_q;
    assign mem_rd  = stb_q.mem_rd;
    assign ir_load = stb_q.ir_load;
    assign pc_inc  = stb_q.pc_inc;
    assign exec_en = stb_q.exec_en;
    assign wb_en   = stb_q.wb_en;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: two parameterisations share stimulus; expected outputs are queued per cycle.
module tb_cpu_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2, S_HALT = 2'd3;
    // strobe order {mem_rd, ir_load, pc_inc, exec_en, wb_en}
    localparam logic [4:0] K_NONE = 5'b00000, K_RD = 5'b10000, K_LD = 5'b11000;
    localparam logic [4:0] K_PC = 5'b00100, K_EX = 5'b00010, K_WB = 5'b00001;

    typedef struct packed {
        logic        sel;      // 0 = dut_a (defaults), 1 = dut_b (CNT_W=4, TIMEOUT=4)
        logic [3:0]  t;
        logic [1:0]  st;
        logic [4:0]  stb;
        logic        fault;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        logic start;
        logic stop;
        logic step;
        logic halt;
        logic mr;
        exp_t e;
    } vec_t;

    logic clk, rst, start, stop, step_mode, halt_req, mem_ready;
    logic [3:0]  a_t, b_t;
    logic [1:0]  a_state, b_state;
    logic        a_mem_rd, a_ir_load, a_pc_inc, a_exec_en, a_wb_en, a_fault;
    logic        b_mem_rd, b_ir_load, b_pc_inc, b_exec_en, b_wb_en, b_fault;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_id = 0;

    cpu_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
        .halt_req(halt_req), .mem_ready(mem_ready), .t(a_t), .state(a_state),
        .mem_rd(a_mem_rd), .ir_load(a_ir_load), .pc_inc(a_pc_inc), .exec_en(a_exec_en),
        .wb_en(a_wb_en), .fault(a_fault), .instr_cnt(a_cnt)
    );

    cpu_sequencer #(.CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode),
        .halt_req(halt_req), .mem_ready(mem_ready), .t(b_t), .state(b_state),
        .mem_rd(b_mem_rd), .ir_load(b_ir_load), .pc_inc(b_pc_inc), .exec_en(b_exec_en),
        .wb_en(b_wb_en), .fault(b_fault), .instr_cnt(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk(input logic sel, input logic [3:0] t, input logic [1:0] st,
                                input logic [4:0] stb, input logic f, input logic [15:0] cnt);
        exp_t e;
        e.sel = sel; e.t = t; e.st = st; e.stb = stb; e.fault = f; e.cnt = cnt;
        return e;
    endfunction

    function automatic void add_row(input logic s, input logic sp, input logic sm,
                                    input logic h, input logic mr, input exp_t e);
        vec_t v;
        v.start = s; v.stop = sp; v.step = sm; v.halt = h; v.mr = mr; v.e = e;
        tbl.push_back(v);
    endfunction

    // Unstalled instruction beats starting at FETCH T0; cnt is the value shown throughout.
    function automatic void add_instr(input logic sel, input logic [15:0] cnt, input logic step,
                                      input logic halt, input int stop_at, input int beats);
        logic [4:0] stb;
        for (int i = 0; i < beats; i++) begin
            case (i)
                0: stb = K_RD;
                1: stb = K_LD;
                2: stb = K_PC;
                5: stb = K_EX;
                7: stb = K_WB;
                default: stb = K_NONE;
            endcase
            add_row(1'b0, (i == stop_at), step, (i == 7) ? halt : 1'b0, 1'b1,
                    mk(sel, 4'b0001 << (i % 4), (i < 4) ? S_FETCH : S_EXEC, stb, 1'b0, cnt));
        end
    endfunction

    // Drive one row per cycle, queue its expectation, then pop and compare at the falling edge.
    task automatic run_tbl();
        exp_t e, a;
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            start = tbl[i].start; stop = tbl[i].stop; step_mode = tbl[i].step;
            halt_req = tbl[i].halt; mem_ready = tbl[i].mr;
            sb.push_back(tbl[i].e);
            @(negedge clk); #1;
            e = sb.pop_front();
            if (e.sel)
                a = mk(1'b1, b_t, b_state, {b_mem_rd, b_ir_load, b_pc_inc, b_exec_en, b_wb_en},
                       b_fault, {12'd0, b_cnt});
            else
                a = mk(1'b0, a_t, a_state, {a_mem_rd, a_ir_load, a_pc_inc, a_exec_en, a_wb_en},
                       a_fault, a_cnt);
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d dut_%s: got t=%b st=%0d stb=%b fault=%b cnt=%0d, expected t=%b st=%0d stb=%b fault=%b cnt=%0d",
                         vec_id, e.sel ? "b" : "a", a.t, a.st, a.stb, a.fault, a.cnt,
                         e.t, e.st, e.stb, e.fault, e.cnt);
            end
            vec_id++;
        end
        tbl.delete();
    endtask

    task automatic chk_zero(input string name);
        n_cmp++;
        if ({a_t, a_state, a_mem_rd, a_ir_load, a_pc_inc, a_exec_en, a_wb_en, a_fault, a_cnt} !== '0) begin
            n_bad++;
            $display("FAIL %s dut_a: got t=%b st=%0d stb=%b fault=%b cnt=%0d, expected all zero", name,
                     a_t, a_state, {a_mem_rd, a_ir_load, a_pc_inc, a_exec_en, a_wb_en}, a_fault, a_cnt);
        end
        n_cmp++;
        if ({b_t, b_state, b_mem_rd, b_ir_load, b_pc_inc, b_exec_en, b_wb_en, b_fault, b_cnt} !== '0) begin
            n_bad++;
            $display("FAIL %s dut_b: got t=%b st=%0d stb=%b fault=%b cnt=%0d, expected all zero", name,
                     b_t, b_state, {b_mem_rd, b_ir_load, b_pc_inc, b_exec_en, b_wb_en}, b_fault, b_cnt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        start = 0; stop = 0; step_mode = 0; halt_req = 0; mem_ready = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 0; stop = 0; step_mode = 0; halt_req = 0; mem_ready = 0;
        #50 chk_zero("reset_hold");
        #50 rst = 1'b1;

        // Run, stall of five cycles, then stop in FETCH T2 overridden by halt_req at EXEC T3.
        add_row(1, 0, 0, 0, 1, mk(0, 4'b0000, S_IDLE, K_NONE, 0, 16'd0));
        add_instr(0, 16'd0, 0, 0, -1, 8);
        add_row(0, 0, 0, 0, 0, mk(0, 4'b0001, S_FETCH, K_RD, 0, 16'd1));
        for (int i = 0; i < 5; i++)
            add_row(0, 0, 0, 0, (i == 4), mk(0, 4'b0010, S_FETCH, K_RD, 0, 16'd1));
        add_row(0, 0, 0, 0, 1, mk(0, 4'b0010, S_FETCH, K_LD, 0, 16'd1));
        add_row(0, 1, 0, 0, 1, mk(0, 4'b0100, S_FETCH, K_PC, 0, 16'd1));
        add_row(0, 0, 0, 0, 1, mk(0, 4'b1000, S_FETCH, K_NONE, 0, 16'd1));
        add_row(0, 0, 0, 0, 1, mk(0, 4'b0001, S_EXEC, K_NONE, 0, 16'd1));
        add_row(0, 0, 0, 0, 1, mk(0, 4'b0010, S_EXEC, K_EX, 0, 16'd1));
        add_row(0, 0, 0, 0, 1, mk(0, 4'b0100, S_EXEC, K_NONE, 0, 16'd1));
        add_row(0, 0, 0, 1, 1, mk(0, 4'b1000, S_EXEC, K_WB, 0, 16'd1));
        add_row(1, 0, 0, 0, 1, mk(0, 4'b0000, S_HALT, K_NONE, 0, 16'd2));
        add_row(0, 1, 1, 0, 1, mk(0, 4'b0000, S_HALT, K_NONE, 0, 16'd2));
        add_row(0, 0, 0, 0, 1, mk(0, 4'b0000, S_HALT, K_NONE, 0, 16'd2));
        run_tbl();

        // Stall timeout on the TIMEOUT=4 instance.
        do_reset();
        add_row(1, 0, 0, 0, 0, mk(1, 4'b0000, S_IDLE, K_NONE, 0, 16'd0));
        add_row(0, 0, 0, 0, 0, mk(1, 4'b0001, S_FETCH, K_RD, 0, 16'd0));
        for (int i = 0; i < 4; i++)
            add_row(0, 0, 0, 0, 0, mk(1, 4'b0010, S_FETCH, K_RD, 0, 16'd0));
        add_row(0, 0, 0, 0, 0, mk(1, 4'b0000, S_HALT, K_NONE, 1, 16'd0));
        add_row(1, 0, 0, 0, 1, mk(1, 4'b0000, S_HALT, K_NONE, 1, 16'd0));
        add_row(0, 0, 0, 0, 1, mk(1, 4'b0000, S_HALT, K_NONE, 1, 16'd0));
        run_tbl();

        // Start with stop stays idle; three single steps; stop latched in EXEC T0 returns to idle.
        do_reset();
        add_row(1, 1, 0, 0, 1, mk(0, 4'b0000, S_IDLE, K_NONE, 0, 16'd0));
        add_row(0, 0, 0, 0, 1, mk(0, 4'b0000, S_IDLE, K_NONE, 0, 16'd0));
        for (int k = 0; k < 3; k++) begin
            add_row(1, 0, 1, 0, 1, mk(0, 4'b0000, S_IDLE, K_NONE, 0, 16'(k)));
            add_instr(0, 16'(k), 1, 0, -1, 8);
        end
        add_row(0, 0, 1, 0, 1, mk(0, 4'b0000, S_IDLE, K_NONE, 0, 16'd3));
        add_row(1, 0, 0, 0, 1, mk(0, 4'b0000, S_IDLE, K_NONE, 0, 16'd3));
        add_instr(0, 16'd3, 0, 0, 4, 8);
        add_row(1, 0, 0, 0, 1, mk(0, 4'b0000, S_IDLE, K_NONE, 0, 16'd4));
        add_instr(0, 16'd4, 0, 0, -1, 8);
        add_row(0, 0, 0, 0, 1, mk(0, 4'b0001, S_FETCH, K_RD, 0, 16'd5));
        run_tbl();

        // Counter wrap on the 4-bit instance, then reset asserted during EXEC T1.
        do_reset();
        add_row(1, 0, 0, 0, 1, mk(1, 4'b0000, S_IDLE, K_NONE, 0, 16'd0));
        for (int k = 0; k < 16; k++)
            add_instr(1, 16'(k), 0, 0, -1, 8);
        add_instr(1, 16'd0, 0, 0, -1, 6);
        run_tbl();
        rst = 1'b0;
        #1 chk_zero("reset_mid_exec");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        add_row(1, 0, 0, 0, 1, mk(1, 4'b0000, S_IDLE, K_NONE, 0, 16'd0));
        add_row(0, 0, 0, 0, 1, mk(1, 4'b0001, S_FETCH, K_RD, 0, 16'd0));
        run_tbl();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the retired-instruction counter.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum number of consecutive stall cycles before a fault.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled per cycle.
REQ-006 SHALL have port stop, input, 1 bit: stop request, sampled per cycle.
REQ-007 SHALL have port step_mode, input, 1 bit: 1 = single-instruction stepping.
REQ-008 SHALL have port halt_req, input, 1 bit: the decoder flags a halt instruction.
REQ-009 SHALL have port mem_ready, input, 1 bit: instruction memory data valid.
REQ-010 SHALL have port t, output, 4 bits: one-hot beat T0..T3 (bit0 = T0).
REQ-011 SHALL have port state, output, 2 bits: IDLE=0, FETCH=1, EXEC=2, HALT=3.
REQ-012 SHALL have port mem_rd, ir_load, pc_inc, exec_en and wb_en, each output, 1 bit: single-cycle control strobes.
REQ-013 SHALL have port fault, output, 1 bit: sticky stall-timeout flag.
REQ-014 SHALL have port instr_cnt, output, CNT_W bits: count of retired instructions.

Function
REQ-015 SHALL drive t = 0000 in IDLE and HALT, and exactly one bit of t in FETCH and EXEC.
REQ-016 SHALL advance t one beat per clk (T0->T1->T2->T3->T0) unless stalled.
REQ-017 SHALL transition IDLE->FETCH at T0 on the cycle after start=1 with stop=0.
REQ-018 SHALL transition FETCH->EXEC on FETCH T3, entering EXEC at T0.
REQ-019 SHALL, on EXEC T3, increment instr_cnt (wrapping modulo 2^CNT_W) and select the next state per REQ-020..REQ-023.
REQ-020 SHALL, on EXEC T3, go to HALT if halt_req=1 (highest priority).
REQ-021 SHALL, on EXEC T3, go to IDLE if a stop was latched during the instruction.
REQ-022 SHALL, on EXEC T3, go to IDLE if step_mode=1.
REQ-023 SHALL, on EXEC T3 when none of REQ-020..REQ-022 applies, go to FETCH T0.
REQ-024 SHALL latch stop for the rest of the current instruction; the latch clears on entering IDLE.
REQ-025 SHALL assert the FETCH strobes as: mem_rd in T0 and T1; ir_load in T1 only when mem_ready=1; pc_inc in T2.
REQ-026 SHALL assert the EXEC strobes as: exec_en in T1; wb_en in T3.
REQ-027 SHALL hold the beat at FETCH T1 with mem_ready=0, keeping mem_rd=1 and all other strobes 0.
REQ-028 SHALL count consecutive stall cycles and clear the count on mem_ready=1.
REQ-029 SHALL, when the stall count reaches TIMEOUT, set fault and go to HALT on the next cycle without asserting ir_load.
REQ-030 SHALL leave HALT only via reset, and SHALL ignore start, stop and step_mode in HALT.
REQ-031 SHALL, in IDLE with start=1 and stop=1 simultaneously, stay in IDLE (stop wins).
REQ-032 SHALL ignore start outside IDLE.
REQ-033 SHALL allow step_mode to change at any time, taking effect at the next EXEC T3.
REQ-034 SHALL register all outputs; strobes SHALL be valid in the same cycle as the corresponding t bit.

Reset
REQ-035 SHALL, on rst=0, immediately (asynchronously) force state=IDLE, t=0000, all strobes 0, fault=0, instr_cnt=0, stall count 0 and the stop latch 0.
REQ-036 SHALL abort any instruction in progress on reset mid-operation, without completing strobes.
REQ-037 SHALL treat the first rising clk edge after rst rises as a normal IDLE cycle.

Structure
REQ-038 SHALL import the state encodings (IDLE/FETCH/EXEC/HALT) and beat one-hot constants (T0..T3) from shared package cpu_seq_pkg.
REQ-039 SHALL contain one sub-module, beat_gen: a 4-bit ring counter with clear, enable and hold inputs producing t.
REQ-040 SHALL keep the FSM, strobe decode, stop latch, stall timer and instr_cnt in cpu_sequencer.

Verification
REQ-041 SHALL cover run: rst low 100 ns then high; start pulse; mem_ready=1 -> t cycles 0001,0010,0100,1000 twice; instr_cnt=1 after 8 beats; state returns to FETCH.
REQ-042 SHALL cover stall: mem_ready=0 for 5 cycles at FETCH T1 -> t holds 0010 for 5 cycles, mem_rd=1, ir_load=0; ir_load=1 on the 6th cycle.
REQ-043 SHALL cover timeout: TIMEOUT=4, mem_ready held 0 -> fault=1, state=HALT, t=0000, instr_cnt unchanged.
REQ-044 SHALL cover step: step_mode=1 with 3 start pulses, each in IDLE -> exactly 3 instructions, instr_cnt=3, state=IDLE between them.
REQ-045 SHALL cover priority: stop asserted in FETCH T2 and halt_req=1 at EXEC T3 -> HALT (not IDLE); a following start is ignored.
REQ-046 SHALL cover wrap and reset: CNT_W=4, 16 instructions -> instr_cnt=0; rst low during EXEC T1 -> all outputs 0 immediately.
